// File: rtl/piso_pattern_feeder.sv
// piso_pattern_feeder: valid/ready parallel word intake into a one-entry
// holding register, serialised MSB-first with an optional idle gap per word.
module piso_pattern_feeder #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             xfer;
  logic             load;

  // Next-state: handshake into hold, shift/gap sequencing, load from hold
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    load           = 1'b0;

    // in_ready_q mirrors !hold_full_q, so a transfer can never meet a load
    xfer = in_valid && in_ready_q;
    if (xfer) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != CW'(0)) begin
          shift_d      = shift_q << 1;
          serial_out_d = shift_q[WIDTH-2];
          cnt_d        = cnt_q - CW'(1);
        end else if (GAP != 0) begin
          state_d        = ST_GAP;
          gap_d          = GW'(GAP - 1);
          serial_out_d   = 1'b0;
          serial_valid_d = 1'b0;
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d        = ST_IDLE;
          serial_out_d   = 1'b0;
          serial_valid_d = 1'b0;
        end
      end

      ST_GAP: begin
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        if (gap_q != GW'(0)) begin
          gap_d = gap_q - GW'(1);
        end else if (hold_full_q) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d        = ST_IDLE;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
      end
    endcase

    // Move the held word into the shifter and present its MSB
    if (load) begin
      shift_d        = hold_q;
      hold_full_d    = 1'b0;
      serial_out_d   = hold_q[WIDTH-1];
      serial_valid_d = 1'b1;
      cnt_d          = CW'(WIDTH - 1);
      state_d        = ST_SHIFT;
    end

    // Registered status flags, decoded from the next registered state
    frame_done_d = (state_d == ST_SHIFT) && (cnt_d == CW'(0));
    in_ready_d   = !hold_full_d;
    busy_d       = (state_d != ST_IDLE) || hold_full_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      shift_q        <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_done_q   <= frame_done_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

endmodule

// File: doc/piso_pattern_feeder.md
Name: piso_pattern_feeder

Overview:
- Parallel-in/serial-out feeder that turns parallel pattern words into the MSB-first serial bit stream consumed by the downstream pattern-match stage on its serial input.
- Accepts words over a valid/ready handshake into a one-entry holding register, then shifts each word out one bit per clock.
- Optional idle gap between words.
- Downstream shift register is always enabled, so there is no backpressure on the serial side.

Parameters:
- WIDTH, 6, bits per word; legal range 2..32.
- GAP, 0, idle cycles inserted after each word; legal range 0..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  parallel word to serialise.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding register empty; a transfer occurs on an edge where in_valid && in_ready.
- serial_out  output  1  current serial bit, registered; drives the matcher's serial input.
- serial_valid  output  1  serial_out carries a data bit this cycle.
- frame_done  output  1  one-cycle pulse, high while the last bit (bit 0) of a word is on serial_out.
- busy  output  1  high in SHIFT or GAP, or while the holding register is full.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; holding register empty; shifter=0; bit counter=0.
  - serial_out=0, serial_valid=0, frame_done=0, in_ready=1, busy=0.
  - rst has priority over every other event. Mid-word reset aborts the word and discards the held word; no partial bits after the reset edge.
- Handshake:
  - in_ready = !hold_full, decoded from registered state only; no combinational path from in_valid.
  - On a transfer, hold <= in_data and hold_full <= 1.
  - in_valid held high while in_ready=0 is ignored; the word is not lost, it transfers once in_ready rises.
- Loading: on any edge where state is IDLE, or at end-of-word/end-of-gap (below), and hold_full=1:
  - shifter <= hold; hold_full <= 0;
  - serial_out <= hold[WIDTH-1]; serial_valid <= 1; counter <= WIDTH-1; state <= SHIFT.
- Latency: a word accepted at edge k shows its MSB on serial_out after edge k+1.
- A transfer into hold and a load out of hold never coincide, because in_ready=0 whenever hold is full.
- State machine:
  - IDLE: serial_valid=0, serial_out=0; go to SHIFT when hold_full.
  - SHIFT: each edge with counter>0 shifts left, serial_out <= next lower bit, counter decrements. frame_done=1 exactly when counter==0.
  - Edge with counter==0:
    - GAP>0: enter GAP, gap counter=GAP-1, serial_valid<=0, serial_out<=0.
    - GAP==0 and hold_full: load next word immediately, giving a back-to-back stream with no bubble.
    - Otherwise: go to IDLE.
  - GAP: serial_valid=0, serial_out=0. When the gap counter reaches 0, load if hold_full, else go to IDLE.
- Throughput: with GAP=0 and the source keeping hold filled, serial_valid stays continuously high. The hold empties at each load, so the next word can be accepted during the current word's WIDTH cycles.
- Counter widths: bit counter is clog2(WIDTH) bits; gap counter is 4 bits. No wrap beyond stated ranges.
- busy = (state!=IDLE) || hold_full.

Test Plan:
- Reset then single word: in_data=6'b101101 accepted at edge 1 -> serial_out 1,0,1,1,0,1 after edges 2..7 with serial_valid=1; frame_done high only in the cycle after edge 7; IDLE with serial_valid=0 after edge 8.
- Back-to-back, GAP=0: words 6'b110000 then 6'b000011, in_valid held high -> 12 consecutive valid bits 110000000011; in_ready low between acceptance and load.
- GAP=3: two words 6'b111111 -> six 1s, exactly 3 cycles serial_valid=0/serial_out=0, six 1s; frame_done pulses twice.
- Backpressure: in_valid=1 with three words queued by the source -> each word transfers only when in_ready=1; no word dropped or duplicated; output order matches input order.
- Reset mid-word: rst=1 after the 3rd bit of 6'b101010 with a second word in hold -> after the reset edge all outputs at reset values, in_ready=1, neither word emitted.
- End-to-end with downstream matcher loaded with pattern 6'b101101: feed 6'b101101 -> pattern_match asserts once all six bits have shifted in.
